// File: rtl/ex_mem_pkg.sv
// Shared types and parameters for the EX/MEM pipeline boundary.
// The capture function applies the zero-register and branch rules to a raw ALU beat.
package ex_mem_pkg;

    localparam int DW      = 64;
    localparam int RW      = 5;
    localparam int XZR_IDX = 31;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [DW-1:0] store_data;
        logic [RW-1:0] rd;
        mem_ctrl_t     ctrl;
        logic          br_taken;
    } ex_mem_beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Writes aimed at the zero register are squashed here so downstream never sees them.
    function automatic ex_mem_beat_t capture_beat(
        input logic [DW-1:0] result,
        input logic [DW-1:0] store_data,
        input logic [RW-1:0] rd,
        input logic          mem_read,
        input logic          mem_write,
        input logic          reg_write,
        input logic          mem_to_reg,
        input logic          branch,
        input logic          alu_zero
    );
        ex_mem_beat_t b;
        logic         is_xzr;
        is_xzr            = (rd == RW'(XZR_IDX));
        b.result          = result;
        b.store_data      = store_data;
        b.rd              = rd;
        b.ctrl.mem_read   = mem_read;
        b.ctrl.mem_write  = mem_write;
        b.ctrl.reg_write  = reg_write & ~is_xzr;
        b.ctrl.mem_to_reg = mem_to_reg & ~is_xzr;
        b.br_taken        = branch & alu_zero;
        return b;
    endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One beat of storage plus its valid flag; payload loads on enable, valid follows valid_d.
// Async reset clears both so the outputs read as zero while reset is held.
module ex_mem_slot
    import ex_mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  ex_mem_beat_t d,
    input  logic         valid_d,
    output ex_mem_beat_t q,
    output logic         valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= valid_d;
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: two-entry skid buffer between the ALU and the data-memory stage.
// All outputs come straight from the main slot registers; in_ready comes from the skid valid flag.
//
// state    | meaning
// ST_EMPTY | no beat held
// ST_ONE   | main slot holds the oldest beat
// ST_FULL  | main holds oldest, skid holds the overflow beat
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    input  logic [DW-1:0] store_data,
    input  logic [RW-1:0] rd,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          reg_write,
    input  logic          mem_to_reg,
    input  logic          branch,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [DW-1:0] out_store_data,
    output logic [RW-1:0] out_rd,
    output logic          out_mem_read,
    output logic          out_mem_write,
    output logic          out_reg_write,
    output logic          out_mem_to_reg,
    output logic          out_br_taken
);

    state_t       state, state_d;
    ex_mem_beat_t in_beat, main_d, main_q, skid_q;
    logic         main_load, skid_load, main_from_skid;
    logic         main_valid, skid_valid;
    logic         in_xfer, out_xfer;

    assign in_beat  = capture_beat(alu_result, store_data, rd, mem_read, mem_write,
                                   reg_write, mem_to_reg, branch, alu_zero);
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d        = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid-to-main shift can happen.
                    if (out_xfer) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_beat;

    ex_mem_slot u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load),
        .d       (main_d),
        .valid_d (state_d != ST_EMPTY),
        .q       (main_q),
        .valid   (main_valid)
    );

    ex_mem_slot u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .d       (in_beat),
        .valid_d (state_d == ST_FULL),
        .q       (skid_q),
        .valid   (skid_valid)
    );

    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_rd         = main_q.rd;
    assign out_mem_read   = main_q.ctrl.mem_read;
    assign out_mem_write  = main_q.ctrl.mem_write;
    assign out_reg_write  = main_q.ctrl.reg_write;
    assign out_mem_to_reg = main_q.ctrl.mem_to_reg;
    assign out_br_taken   = main_q.br_taken;

endmodule
